// File: rtl/mips_pkg.sv
// Shared constants for the MIPS data memory: sizes, MMIO base, register offsets and
// TIMER_CTRL bit positions.
package mips_pkg;

    localparam int unsigned DATA_MEM_WIDTH = 32;
    localparam int unsigned DMEM_DEPTH     = 256;

    localparam logic [31:0] MMIO_BASE        = 32'h8000_0000;
    localparam logic [31:0] OFF_TIMER_CTRL   = 32'h0000_0000;
    localparam logic [31:0] OFF_TIMER_COUNT  = 32'h0000_0004;
    localparam logic [31:0] OFF_TIMER_CMP    = 32'h0000_0008;
    localparam logic [31:0] OFF_TIMER_STATUS = 32'h0000_000C;
    localparam logic [31:0] OFF_LED          = 32'h0000_0010;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_AUTO_BIT = 1;

    // Word-aligned offset from MMIO_BASE; the byte lane bits never take part in decode.
    function automatic logic [31:0] mmio_offset(input logic [31:0] addr);
        return {1'b0, addr[30:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_dmem_timer.sv
// Memory-mapped timer: CTRL/COUNT/CMP/STATUS registers, free-running counter with
// compare match, optional auto-reload and a sticky W1C status bit driving the irq.
module mips_dmem_timer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  logic [31:0] off_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        status_q, status_d;

    logic wr_ctrl, wr_count, wr_cmp, wr_status;
    logic en, match;

    always_comb begin
        wr_ctrl   = wr_en_i && (off_i == OFF_TIMER_CTRL);
        wr_count  = wr_en_i && (off_i == OFF_TIMER_COUNT);
        wr_cmp    = wr_en_i && (off_i == OFF_TIMER_CMP);
        wr_status = wr_en_i && (off_i == OFF_TIMER_STATUS);
        en        = ctrl_q[CTRL_EN_BIT];
        match     = en && (count_q == cmp_q);

        ctrl_d = wr_ctrl ? wdata_i[1:0] : ctrl_q;
        cmp_d  = wr_cmp ? wdata_i : cmp_q;

        // Software write beats both reload and increment.
        count_d = count_q;
        if (wr_count) begin
            count_d = wdata_i;
        end else if (match && ctrl_q[CTRL_AUTO_BIT]) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 32'd1;
        end

        // A match in the same cycle as a clear keeps the bit set.
        status_d = status_q;
        if (match) begin
            status_d = 1'b1;
        end else if (wr_status && wdata_i[0]) begin
            status_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            count_q  <= '0;
            cmp_q    <= '0;
            status_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (off_i)
            OFF_TIMER_CTRL:   rdata_o = {30'b0, ctrl_q};
            OFF_TIMER_COUNT:  rdata_o = count_q;
            OFF_TIMER_CMP:    rdata_o = cmp_q;
            OFF_TIMER_STATUS: rdata_o = {31'b0, status_q};
            default:          rdata_o = '0;
        endcase
    end

    assign irq_o = status_q;

endmodule

// File: rtl/mips_data_mem.sv
// MIPS data memory: word RAM below 0x8000_0000, MMIO (LED, optional timer) above it.
// Define MIPS_DMEM_TIMER_EN to include the timer; otherwise its offsets read 0.
module mips_data_mem
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      memwrite,
    input  logic [DATA_MEM_WIDTH-1:0] memaddr,
    input  logic [DATA_MEM_WIDTH-1:0] writedata,
    output logic [DATA_MEM_WIDTH-1:0] readdata,
    output logic [7:0]                leds,
    output logic                      timer_irq
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_MEM_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]             ram_idx;
    logic                      is_mmio;
    logic [31:0]               off;
    logic                      ram_we, mmio_we;
    logic [7:0]                led_q, led_d;
    logic [31:0]               timer_rdata;
    logic [31:0]               mmio_rdata;
    logic                      unused_addr;

    assign is_mmio     = memaddr[31];
    assign ram_idx     = memaddr[AW+1:2];
    assign off         = mmio_offset(memaddr);
    assign ram_we      = memwrite && !is_mmio;
    assign mmio_we     = memwrite && is_mmio;
    assign unused_addr = ^memaddr[1:0];

    // RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= writedata;
        end
    end

    assign led_d = (mmio_we && (off == OFF_LED)) ? writedata[7:0] : led_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign leds = led_q;

`ifdef MIPS_DMEM_TIMER_EN
    mips_dmem_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (mmio_we),
        .off_i   (off),
        .wdata_i (writedata),
        .rdata_o (timer_rdata),
        .irq_o   (timer_irq)
    );
`else
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:8];
    assign timer_rdata  = '0;
    assign timer_irq    = 1'b0;
`endif

    // Timer returns 0 outside its own offsets, so the LED only needs to override it.
    always_comb begin
        mmio_rdata = timer_rdata;
        if (off == OFF_LED) begin
            mmio_rdata = {24'b0, led_q};
        end
        readdata = is_mmio ? mmio_rdata : mem_q[ram_idx];
    end

endmodule

// File: tb/tb_mips_data_mem.sv
// Scoreboard bench for mips_data_mem: stimulus pushes expected values, a negedge monitor
// drains and compares them. Timer checks follow MIPS_DMEM_TIMER_EN.
module tb_mips_data_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] memaddr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  leds;
    logic        timer_irq;

    localparam int SEL_RD  = 0;
    localparam int SEL_LED = 1;
    localparam int SEL_IRQ = 2;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    mips_data_mem #(.DEPTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .memwrite  (memwrite),
        .memaddr   (memaddr),
        .writedata (writedata),
        .readdata  (readdata),
        .leds      (leds),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_RD:  act = readdata;
                SEL_LED: act = {24'b0, leds};
                default: act = {31'b0, timer_irq};
            endcase
            n_cmp = n_cmp + 1;
            if (act !== e.val) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s (direct): got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic r = 1'b0);
        @(posedge clk);
        #1;
        rst       = r;
        memwrite  = we;
        memaddr   = a;
        writedata = d;
    endtask

    task automatic push(input string n, input int s, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = s;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b0, a, 32'h0);
    endtask

    localparam logic [31:0] CTRL   = 32'h8000_0000;
    localparam logic [31:0] COUNT  = 32'h8000_0004;
    localparam logic [31:0] CMP    = 32'h8000_0008;
    localparam logic [31:0] STATUS = 32'h8000_000C;
    localparam logic [31:0] LED    = 32'h8000_0010;

    initial begin
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1);

        // Reset state
        rd(LED);
        push("reset_led_rd", SEL_RD, 32'h0);
        push("reset_leds", SEL_LED, 32'h0);
        push("reset_irq", SEL_IRQ, 32'h0);
        rd(COUNT);
        push("reset_count", SEL_RD, 32'h0);
        chk("reset_count_now", readdata, 32'h0);
        chk("reset_irq_now", {31'b0, timer_irq}, 32'h0);

        // RAM write/read and aliasing
        cyc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010);
        push("ram_rd_0x10", SEL_RD, 32'hDEAD_BEEF);
        rd(32'h0000_0410);
        push("ram_alias_0x410", SEL_RD, 32'hDEAD_BEEF);
        rd(32'h0000_0013);
        push("ram_bytelane_0x13", SEL_RD, 32'hDEAD_BEEF);

        // Same-cycle read/write of one word
        cyc(1'b1, 32'h0000_0020, 32'h1111_1111);
        cyc(1'b1, 32'h0000_0020, 32'h2222_2222);
        push("ram_raw_old", SEL_RD, 32'h1111_1111);
        rd(32'h0000_0020);
        push("ram_raw_new", SEL_RD, 32'h2222_2222);

        // LED register and unmapped MMIO
        cyc(1'b1, LED, 32'h1234_5678);
        push("led_rd_before_wr", SEL_RD, 32'h0);
        rd(LED);
        push("leds_out", SEL_LED, 32'h78);
        push("led_rd", SEL_RD, 32'h78);
        cyc(1'b1, 32'h8000_0020, 32'hFFFF_FFFF);
        push("unmapped_rd_in_wr", SEL_RD, 32'h0);
        rd(32'h8000_0020);
        push("unmapped_rd", SEL_RD, 32'h0);
        rd(32'h0000_0020);
        push("ram_untouched_by_mmio", SEL_RD, 32'h2222_2222);
        push("leds_untouched", SEL_LED, 32'h78);

`ifdef MIPS_DMEM_TIMER_EN
        begin
            logic [31:0] cnt_exp [9];
            logic        irq_exp [9];
            cnt_exp = '{0, 1, 2, 3, 4, 5, 0, 1, 2};
            irq_exp = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
            cyc(1'b1, CMP, 32'd5);
            cyc(1'b1, CTRL, 32'h3);
            for (int i = 0; i < 9; i++) begin
                rd(COUNT);
                push($sformatf("count_seq[%0d]", i), SEL_RD, cnt_exp[i]);
                push($sformatf("irq_seq[%0d]", i), SEL_IRQ, {31'b0, irq_exp[i]});
                chk($sformatf("count_seq_now[%0d]", i), readdata, cnt_exp[i]);
            end
        end
        cyc(1'b1, STATUS, 32'h1);
        push("status_rd_before_w1c", SEL_RD, 32'h1);
        push("irq_before_w1c", SEL_IRQ, 32'h1);
        rd(STATUS);
        push("status_after_w1c", SEL_RD, 32'h0);
        push("irq_after_w1c", SEL_IRQ, 32'h0);
        cyc(1'b1, STATUS, 32'h1);
        push("irq_in_match_cycle", SEL_IRQ, 32'h0);
        rd(STATUS);
        push("status_set_wins", SEL_RD, 32'h1);
        push("irq_set_wins", SEL_IRQ, 32'h1);
        cyc(1'b1, COUNT, 32'h100);
        push("count_rd_before_wr", SEL_RD, 32'h1);
        rd(COUNT);
        push("count_sw_write", SEL_RD, 32'h100);
        rd(COUNT);
        push("count_after_sw_write", SEL_RD, 32'h101);
        cyc(1'b1, STATUS, 32'h0);
        rd(STATUS);
        push("status_w0_no_effect", SEL_RD, 32'h1);
        push("irq_w0_no_effect", SEL_IRQ, 32'h1);
        rd(CTRL);
        push("ctrl_rd", SEL_RD, 32'h3);

        // Counter wrap
        cyc(1'b1, CTRL, 32'h1);
        cyc(1'b1, COUNT, 32'hFFFF_FFFE);
        rd(COUNT);
        push("wrap_fffffffe", SEL_RD, 32'hFFFF_FFFE);
        rd(COUNT);
        push("wrap_ffffffff", SEL_RD, 32'hFFFF_FFFF);
        rd(COUNT);
        push("wrap_zero", SEL_RD, 32'h0);
`else
        cyc(1'b1, CTRL, 32'h1);
        cyc(1'b1, CMP, 32'd5);
        rd(CTRL);
        push("notimer_ctrl_rd", SEL_RD, 32'h0);
        repeat (10) cyc(1'b0, 32'h0, 32'h0);
        rd(COUNT);
        push("notimer_count_rd", SEL_RD, 32'h0);
        push("notimer_irq", SEL_IRQ, 32'h0);
        chk("notimer_count_after_wait", readdata, 32'h0);
        chk("notimer_irq_after_wait", {31'b0, timer_irq}, 32'h0);
        rd(CMP);
        push("notimer_cmp_rd", SEL_RD, 32'h0);
        rd(STATUS);
        push("notimer_status_rd", SEL_RD, 32'h0);
`endif

        // Reset while running: reset beats the same-cycle LED write
        cyc(1'b1, LED, 32'hFF);
        cyc(1'b1, LED, 32'hAA, 1'b1);
        rd(COUNT);
        push("rst_leds", SEL_LED, 32'h0);
        push("rst_irq", SEL_IRQ, 32'h0);
        push("rst_count", SEL_RD, 32'h0);
        rd(COUNT);
        push("rst_count_frozen", SEL_RD, 32'h0);
        rd(CTRL);
        push("rst_ctrl", SEL_RD, 32'h0);
        rd(STATUS);
        push("rst_status", SEL_RD, 32'h0);
        push("rst_irq_hold", SEL_IRQ, 32'h0);
        rd(CMP);
        push("rst_cmp", SEL_RD, 32'h0);
        rd(LED);
        push("rst_led_rd", SEL_RD, 32'h0);

        cyc(1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_data_mem.md
MIPS_DATA_MEM -- requirements
Module: mips_data_mem

Interface
REQ-001 Parameter DEPTH, default 256, RAM size in 32-bit words; power of two, 16..4096.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 memwrite  input  1  write strobe from core, one write per cycle.
REQ-005 memaddr  input  DATA_MEM_WIDTH  byte address from core ALU.
REQ-006 writedata  input  DATA_MEM_WIDTH  store data.
REQ-007 readdata  output  DATA_MEM_WIDTH  load data, combinational from memaddr.
REQ-008 leds  output  8  LED register value.
REQ-009 timer_irq  output  1  level, equals TIMER_STATUS bit0.

Function
REQ-010 Decode: memaddr[31]=0 selects RAM; memaddr[31]=1 selects MMIO; memaddr[1:0] ignored everywhere.
REQ-011 RAM index = memaddr[log2(DEPTH)+1:2]; higher bits ignored, so addresses alias modulo DEPTH words.
REQ-012 RAM write: memwrite=1 -> word stored at rising edge; read is asynchronous, zero-cycle latency.
REQ-013 Same-cycle read and write of one location: readdata shows old value; new value visible next cycle.
REQ-014 MMIO map (offset from 0x8000_0000): 0x00 TIMER_CTRL, 0x04 TIMER_COUNT, 0x08 TIMER_CMP, 0x0C TIMER_STATUS, 0x10 LED.
REQ-015 TIMER_CTRL: bit0 EN, bit1 AUTO_RELOAD; other bits read 0.
REQ-016 EN=1 -> TIMER_COUNT increments by 1 each cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-017 Cycle where EN=1 and COUNT==CMP -> STATUS bit0 set next edge; if AUTO_RELOAD=1, COUNT loads 0 that edge instead of incrementing.
REQ-018 STATUS bit0 sticky; cleared only by writing 1 to bit0 (W1C); writing 0 has no effect.
REQ-019 Simultaneous match and W1C -> set wins (bit stays 1).
REQ-020 Software write to TIMER_COUNT in same cycle as increment/reload -> written value wins.
REQ-021 LED register: writes capture writedata[7:0]; reads return zero-extended value.
REQ-022 Reads of unmapped MMIO offsets return 0; writes to them ignored; no side effects on any read.
REQ-023 MMIO reads return register value before any same-cycle write.

Reset
REQ-024 rst=1 at edge: CTRL, COUNT, CMP, STATUS, LED all load 0; leds=0, timer_irq=0 next cycle.
REQ-025 Reset wins over any same-cycle write or timer event; RAM contents not reset (undefined until written).
REQ-026 Reset mid-count stops timer (EN=0) and clears pending match.

Configuration
REQ-027 Macro MIPS_DMEM_TIMER_EN defined: timer registers and timer_irq behave per REQ-015..020.
REQ-028 Macro undefined: timer logic absent; offsets 0x00..0x0C read 0, writes ignored; timer_irq tied 0; RAM and LED unchanged.

Structure
REQ-029 mips_pkg holds DMEM_DEPTH default, MMIO_BASE, offset constants for each register, CTRL bit positions.
REQ-030 Timer in sub-module mips_dmem_timer (regs, counter, match, W1C); top holds RAM, decoder, LED, read mux.

Verification
REQ-031 Write 0xDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0410 (DEPTH=256) -> both 0xDEAD_BEEF.
REQ-032 Write 0x1234_5678 to 0x8000_0010 -> leds=0x78; read 0x8000_0010 -> 0x0000_0078; read 0x8000_0020 -> 0.
REQ-033 CMP=5, CTRL=0x3 -> COUNT sequence 0..5,0,1..; timer_irq rises one cycle after COUNT==5, stays high until W1C 0x1 to 0x8000_000C.
REQ-034 W1C issued in exact match cycle -> timer_irq remains 1; write of 0x100 to COUNT during running timer -> next read 0x100.
REQ-035 Timer running with STATUS=1, LED=0xFF, assert rst one cycle -> all regs 0, timer_irq=0, leds=0, COUNT frozen at 0.
REQ-036 Build without MIPS_DMEM_TIMER_EN: CTRL=0x1 then wait 10 cycles -> COUNT reads 0, timer_irq=0.
